// File: rtl/subps_ctrl.sv
// subps_ctrl: owner of the SubPS branch-flag table (DEPTH x 1 bit).
// Arbitrates single-port access between one config port and two lookup
// ports, and sequences the power-up (INIT) and commanded (CLEAR) table wipe.
//
// Ports:
//   CP                   clock, rising edge
//   MR                   synchronous active-low reset
//   LA_Send/LA_Addr      lookup request A (level, held until LA_Ack)
//   LA_Ack/LA_MF         one-cycle completion pulse A / looked-up flag (held)
//   LB_*                 same as A, for port B
//   CF_Send/CF_Op        config request; op 01 write, 10 clear-all, 11 read, 00 no-op
//   CF_Addr/CF_Data      config address / write data
//   CF_Ack/CF_Rdata      one-cycle config completion pulse / read-back data (held)
//   Busy                 high while INIT or CLEAR is wiping the table
//   Err                  pulse with any Ack whose address is out of range
module subps_ctrl #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 7
) (
    input  logic          CP,
    input  logic          MR,
    input  logic          LA_Send,
    input  logic [AW-1:0] LA_Addr,
    output logic          LA_Ack,
    output logic          LA_MF,
    input  logic          LB_Send,
    input  logic [AW-1:0] LB_Addr,
    output logic          LB_Ack,
    output logic          LB_MF,
    input  logic          CF_Send,
    input  logic [1:0]    CF_Op,
    input  logic [AW-1:0] CF_Addr,
    input  logic          CF_Data,
    output logic          CF_Ack,
    output logic          CF_Rdata,
    output logic          Busy,
    output logic          Err
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW-1:0] PtrLast = IW'(DEPTH - 1);
    localparam logic [AW:0]   DepthLim = (AW + 1)'(DEPTH);

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpClear = 2'b10;
    localparam logic [1:0] OpRead  = 2'b11;

    typedef enum logic [1:0] {StInit, StIdle, StClear} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             rr_q, rr_d;  // 0: A wins a tie, 1: B wins a tie
    logic [DEPTH-1:0] table_q, table_d;
    logic             la_ack_q, la_ack_d, lb_ack_q, lb_ack_d, cf_ack_q, cf_ack_d;
    logic             la_mf_q, la_mf_d, lb_mf_q, lb_mf_d, cf_rdata_q, cf_rdata_d;
    logic             err_q, err_d;

    logic cf_req, la_req, lb_req;
    logic cf_in, la_in, lb_in;

    // A port is never re-granted while its own Ack is showing.
    assign cf_req = CF_Send && !cf_ack_q;
    assign la_req = LA_Send && !la_ack_q;
    assign lb_req = LB_Send && !lb_ack_q;

    assign cf_in = ({1'b0, CF_Addr} < DepthLim);
    assign la_in = ({1'b0, LA_Addr} < DepthLim);
    assign lb_in = ({1'b0, LB_Addr} < DepthLim);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rr_d       = rr_q;
        table_d    = table_q;
        la_ack_d   = 1'b0;
        lb_ack_d   = 1'b0;
        cf_ack_d   = 1'b0;
        err_d      = 1'b0;
        la_mf_d    = la_mf_q;
        lb_mf_d    = lb_mf_q;
        cf_rdata_d = cf_rdata_q;

        unique case (state_q)
            StInit, StClear: begin
                table_d[ptr_q] = 1'b0;
                ptr_d          = ptr_q + IW'(1);
                if (ptr_q == PtrLast) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                    // Clear-all completes here; power-up wipe ends silently.
                    cf_ack_d = (state_q == StClear);
                end
            end
            StIdle: begin
                if (cf_req) begin
                    cf_ack_d = 1'b1;
                    unique case (CF_Op)
                        OpWrite: begin
                            if (cf_in) table_d[CF_Addr[IW-1:0]] = CF_Data;
                            err_d = !cf_in;
                        end
                        OpClear: begin
                            // Ack is deferred until the wipe finishes.
                            cf_ack_d = 1'b0;
                            state_d  = StClear;
                            ptr_d    = '0;
                        end
                        OpRead: begin
                            cf_rdata_d = cf_in && table_q[CF_Addr[IW-1:0]];
                            err_d      = !cf_in;
                        end
                        OpNop: ;
                        default: ;
                    endcase
                end else if (la_req && (!lb_req || !rr_q)) begin
                    la_ack_d = 1'b1;
                    la_mf_d  = la_in && table_q[LA_Addr[IW-1:0]];
                    err_d    = !la_in;
                    rr_d     = 1'b1;
                end else if (lb_req) begin
                    lb_ack_d = 1'b1;
                    lb_mf_d  = lb_in && table_q[LB_Addr[IW-1:0]];
                    err_d    = !lb_in;
                    rr_d     = 1'b0;
                end
            end
            default: begin
                state_d = StInit;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (!MR) begin
            state_q    <= StInit;
            ptr_q      <= '0;
            rr_q       <= 1'b0;
            la_ack_q   <= 1'b0;
            lb_ack_q   <= 1'b0;
            cf_ack_q   <= 1'b0;
            la_mf_q    <= 1'b0;
            lb_mf_q    <= 1'b0;
            cf_rdata_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rr_q       <= rr_d;
            la_ack_q   <= la_ack_d;
            lb_ack_q   <= lb_ack_d;
            cf_ack_q   <= cf_ack_d;
            la_mf_q    <= la_mf_d;
            lb_mf_q    <= lb_mf_d;
            cf_rdata_q <= cf_rdata_d;
            err_q      <= err_d;
        end
    end

    // Table contents are established by the INIT wipe, so no reset here.
    always_ff @(posedge CP) begin
        table_q <= table_d;
    end

    assign LA_Ack   = la_ack_q;
    assign LA_MF    = la_mf_q;
    assign LB_Ack   = lb_ack_q;
    assign LB_MF    = lb_mf_q;
    assign CF_Ack   = cf_ack_q;
    assign CF_Rdata = cf_rdata_q;
    assign Err      = err_q;
    assign Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_subps_ctrl.sv
// Directed self-checking bench for subps_ctrl. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_subps_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 7;

    logic          CP = 1'b0;
    logic          MR;
    logic          LA_Send, LB_Send, CF_Send, CF_Data;
    logic [AW-1:0] LA_Addr, LB_Addr, CF_Addr;
    logic [1:0]    CF_Op;
    logic          LA_Ack, LA_MF, LB_Ack, LB_MF, CF_Ack, CF_Rdata, Busy, Err;

    int checks = 0;
    int errors = 0;
    logic [DEPTH-1:0] model;

    subps_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CP(CP), .MR(MR),
        .LA_Send(LA_Send), .LA_Addr(LA_Addr), .LA_Ack(LA_Ack), .LA_MF(LA_MF),
        .LB_Send(LB_Send), .LB_Addr(LB_Addr), .LB_Ack(LB_Ack), .LB_MF(LB_MF),
        .CF_Send(CF_Send), .CF_Op(CF_Op), .CF_Addr(CF_Addr), .CF_Data(CF_Data),
        .CF_Ack(CF_Ack), .CF_Rdata(CF_Rdata), .Busy(Busy), .Err(Err)
    );

    always #5 CP = ~CP;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Config transaction; lat counts falling edges until CF_Ack (1 = uncontended).
    task automatic cf_txn(input logic [1:0] op, input logic [AW-1:0] addr, input logic d,
                          output int lat, output logic rdata, output logic err);
        CF_Op = op; CF_Addr = addr; CF_Data = d; CF_Send = 1'b1; lat = 0;
        do begin
            @(negedge CP);
            lat++;
        end while (CF_Ack !== 1'b1 && lat < 200);
        rdata = CF_Rdata; err = Err; CF_Send = 1'b0;
        @(negedge CP);
    endtask

    task automatic lk_txn(input bit port_b, input logic [AW-1:0] addr,
                          output int lat, output logic mf, output logic err);
        if (port_b) begin LB_Addr = addr; LB_Send = 1'b1; end
        else begin LA_Addr = addr; LA_Send = 1'b1; end
        lat = 0;
        do begin
            @(negedge CP);
            lat++;
        end while ((port_b ? LB_Ack : LA_Ack) !== 1'b1 && lat < 200);
        mf = port_b ? LB_MF : LA_MF; err = Err;
        LA_Send = 1'b0; LB_Send = 1'b0;
        @(negedge CP);
    endtask

    task automatic cfg_write(input logic [AW-1:0] addr, input logic d, input logic exp_err);
        int lat; logic rd, er;
        cf_txn(2'b01, addr, d, lat, rd, er);
        check("wr_lat", lat, 1);
        check("wr_err", er, exp_err);
    endtask

    task automatic cfg_read(input logic [AW-1:0] addr, input logic exp, input logic exp_err);
        int lat; logic rd, er;
        cf_txn(2'b11, addr, 1'b0, lat, rd, er);
        check("rd_lat", lat, 1);
        check("rd_data", rd, exp);
        check("rd_err", er, exp_err);
    endtask

    task automatic lookup(input bit port_b, input logic [AW-1:0] addr, input logic exp_mf,
                          input logic exp_err, input string tag);
        int lat; logic mf, er;
        lk_txn(port_b, addr, lat, mf, er);
        check({tag, "_lat"}, lat, 1);
        check({tag, "_mf"}, mf, exp_mf);
        check({tag, "_err"}, er, exp_err);
    endtask

    // Called on the falling edge where MR has just been released.
    task automatic measure_init(output int busy_cycles, output bit saw_ack);
        busy_cycles = 0; saw_ack = 0;
        if (Busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 200; i++) begin
            @(negedge CP);
            if (CF_Ack !== 1'b0 || LA_Ack !== 1'b0 || LB_Ack !== 1'b0) saw_ack = 1;
            if (Busy !== 1'b1) break;
            busy_cycles++;
        end
    endtask

    initial begin
        int bc, lat, busy_n;
        bit sa, la_early, cf_seen;
        logic [2:0] exp_pat [6];

        MR = 1'b0; LA_Send = 0; LB_Send = 0; CF_Send = 0; CF_Data = 0;
        LA_Addr = '0; LB_Addr = '0; CF_Addr = '0; CF_Op = 2'b00;

        // Reset held for 3 cycles.
        repeat (3) begin
            @(negedge CP);
            check("rst_busy", Busy, 1);
            check("rst_outs", {CF_Ack, LA_Ack, LB_Ack, Err, LA_MF, LB_MF, CF_Rdata}, 0);
        end
        MR = 1'b1;
        measure_init(bc, sa);
        check("init_len", bc, 64);
        check("init_ack", sa, 0);
        model = '0;
        lookup(0, 5, 1'b0, 1'b0, "lk5");

        // Write then lookup.
        cfg_write(1, 1'b1, 1'b0); model[1] = 1'b1;
        cfg_write(2, 1'b1, 1'b0); model[2] = 1'b1;
        lookup(0, 1, 1'b1, 1'b0, "lka1");
        lookup(0, 2, 1'b1, 1'b0, "lka2");
        lookup(0, 3, 1'b0, 1'b0, "lka3");
        // B lookup hands the round-robin tie back to A.
        lookup(1, 2, 1'b1, 1'b0, "lkb2");

        // Contention: config first, then A, B alternating every cycle.
        exp_pat = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
        LA_Addr = 1; LB_Addr = 3; LA_Send = 1; LB_Send = 1;
        CF_Op = 2'b11; CF_Addr = 2; CF_Send = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CP);
            check("cont_acks", {CF_Ack, LA_Ack, LB_Ack}, exp_pat[i]);
            if (i == 0) begin
                check("cont_rdata", CF_Rdata, 1);
                CF_Send = 0;
            end
            if (exp_pat[i][1]) check("cont_amf", LA_MF, 1);
            if (exp_pat[i][0]) check("cont_bmf", LB_MF, 0);
        end
        LA_Send = 0; LB_Send = 0;
        @(negedge CP);
        check("cont_quiet", {CF_Ack, LA_Ack, LB_Ack}, 0);

        // Clear-all with a lookup queued behind it.
        cfg_write(0, 1'b1, 1'b0);
        cfg_write(31, 1'b1, 1'b0);
        cfg_write(63, 1'b1, 1'b0);
        cfg_read(63, 1'b1, 1'b0);
        CF_Op = 2'b10; CF_Send = 1;
        @(negedge CP);
        lat = 1; busy_n = 0; la_early = 0;
        if (Busy === 1'b1) busy_n++;
        LA_Addr = 63; LA_Send = 1;
        while (CF_Ack !== 1'b1 && lat < 200) begin
            @(negedge CP);
            lat++;
            if (Busy === 1'b1) busy_n++;
            if (LA_Ack !== 1'b0) la_early = 1;
        end
        // Ack lands 64 cycles later than a single-cycle transaction's would.
        check("clr_lat", lat, 65);
        check("clr_busy_len", busy_n, 64);
        check("clr_busy_end", Busy, 0);
        check("clr_la_early", la_early, 0);
        CF_Send = 0;
        lat = 0;
        do begin
            @(negedge CP);
            lat++;
        end while (LA_Ack !== 1'b1 && lat < 200);
        check("clr_la_lat", lat, 1);
        check("clr_la_mf", LA_MF, 0);
        LA_Send = 0;
        @(negedge CP);
        model = '0;
        cfg_read(0, 1'b0, 1'b0);
        cfg_read(31, 1'b0, 1'b0);

        // Range: out-of-range lookups read 0, writes do nothing, Err flags both.
        cfg_write(0, 1'b1, 1'b0); model[0] = 1'b1;
        cfg_write(5, 1'b1, 1'b0); model[5] = 1'b1;
        lookup(0, 64, 1'b0, 1'b1, "lk64");
        lookup(1, 127, 1'b0, 1'b1, "lkb127");
        cfg_write(100, 1'b1, 1'b1);
        cfg_read(100, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cfg_read(AW'(i), model[i], 1'b0);

        // Reset during CLEAR at ptr 20: no Ack, full INIT follows.
        CF_Op = 2'b10; CF_Send = 1; cf_seen = 0;
        repeat (21) begin
            @(negedge CP);
            if (CF_Ack !== 1'b0) cf_seen = 1;
        end
        check("mid_busy", Busy, 1);
        MR = 1'b0;
        @(negedge CP);
        check("mid_rst_outs", {CF_Ack, Busy}, 2'b01);
        CF_Send = 0;
        MR = 1'b1;
        measure_init(bc, sa);
        check("mid_init_len", bc, 64);
        check("mid_no_ack", cf_seen | sa, 0);
        model = '0;
        lookup(0, 5, 1'b0, 1'b0, "mid_lk5");
        cfg_read(0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
